logical_seq_arb: RTL and testbench
==================================

Name: logical_seq_arb

Overview:
- Shares one 8-bit bytewise logical unit between two requesters. Each requester issues W-bit AND/OR operations.
- Round-robin arbitration picks one request, which is then sequenced one byte per cycle through the unit, LSB first.
- The assembled W-bit result is returned on a valid/ready response port.
- Sits between the execute-stage issue logic and the existing 8-bit logical unit (`logical`: OA=1 gives AND, OA=0 gives OR).

Parameters:
- NBYTES, 4: operand width in bytes. Must be ≥1. Local W = 8*NBYTES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  W  operand A.
- req0_b  in  W  operand B.
- req0_oa  in  1  1=AND, 0=OR.
- req1_valid, req1_ready, req1_a, req1_b, req1_oa: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_y  out  W  result.
- rsp_id  out  1  index of the requester that owns rsp_y.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). rst dominates every other input in the same cycle.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_y=0, rsp_id=0.
  - Byte index=0, last_grant=1, so requester 0 wins the first tie.
  - req0_ready=req1_ready=0 except as defined in IDLE.
- States: IDLE, RUN, RESP.
- IDLE:
  - If only reqN_valid=1, then reqN_ready=1.
  - If both are valid, ready goes to the requester ≠ last_grant.
  - If neither is valid, both readies are 0.
  - Ready is combinational from valid, in IDLE only; it is 0 in RUN and RESP.
  - On handshake (valid & ready), capture a, b, oa and id into holding registers, clear the byte index and result register, and go to RUN.
- RUN:
  - Each cycle, drive the unit with A[8i+7:8i], B[8i+7:8i] and the captured oa, where i is the byte index.
  - Write the unit's Y into result byte i at the clock edge.
  - If i==NBYTES-1, go to RESP; otherwise i←i+1. The index never wraps past NBYTES-1.
- RESP:
  - rsp_valid=1. rsp_y and rsp_id are held stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge: rsp_valid←0, last_grant←rsp_id, go to IDLE.
- Latency: handshake at edge T, RUN occupies cycles T+1..T+NBYTES, rsp_valid=1 from cycle T+NBYTES+1.
  - Minimum throughput is one op per NBYTES+2 cycles.
  - There is no overlap: a new request is not accepted in the cycle the response is consumed.
- Requester inputs may change after the handshake without affecting the in-flight op, because operands are captured.
- No back-pressure loss: an unaccepted request stays pending at the requester and is never dropped by this block.
- Reset mid-operation (RUN or RESP): the op is discarded, no response is produced, all registers return to reset values, and last_grant returns to 1.
- The unit operates purely bitwise, so no carry/width interaction between bytes. Result bits above W do not exist.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/RESP) and the OA encoding constants (OA_AND=1, OA_OR=0).
- One sub-module: instantiate the existing `logical` 8-bit unit, unmodified, for the byte datapath.
- Arbitration is a small inline function, not a separate module.

Test Plan:
1. Req0 only: a=0xF0F01234, b=0x0FF0FF00, oa=1 → req0_ready=1 in accept cycle, rsp_valid rises 5 cycles after the handshake edge (NBYTES=4), rsp_y=0x00F01200, rsp_id=0.
2. Req1 only: a=0x80000001, b=0x00000100, oa=0 → rsp_y=0x80000101, rsp_id=1.
3. Both valid continuously from reset, rsp_ready=1 → grant order 0,1,0,1, with rsp_id alternating and each result correct.
4. rsp_ready held low for 3 cycles during RESP → rsp_valid, rsp_y and rsp_id stay constant; both readies stay 0 while a pending req0_valid=1 waits; req0 is accepted in IDLE after the consume.
5. rst pulsed during the RUN cycle for byte 2 → the next cycle is IDLE with rsp_valid=0 and rsp_y=0; no response ever appears for that op; the next tie grants requester 0.
6. NBYTES=1, a=0x3C, b=0x0F, oa=0 → rsp_y=0x3F, rsp_valid 2 cycles after the handshake edge.

Source files
------------

// File: rtl/logical_seq_arb_pkg.sv
// logical_seq_arb shared package: FSM state codes
// and operation-select encodings.
package logical_seq_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic OA_AND = 1'b1;
  localparam logic OA_OR  = 1'b0;

endpackage

// File: rtl/logical_seq_arb_logical.sv
// logical: 8-bit bytewise logic unit.
// A,B operands, OA select (1=AND, 0=OR), Y result.
module logical
  import logical_seq_arb_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       OA,
  output logic [7:0] Y
);

  always_comb begin
    Y = A | B;
    unique case (1'b1)
      (OA == OA_AND): Y = A & B;
      (OA == OA_OR):  Y = A | B;
      default:        Y = A | B;
    endcase
  end

endmodule

// File: rtl/logical_seq_arb.sv
// logical_seq_arb: two-requester round-robin front end
// that sequences W-bit AND/OR ops through one 8-bit unit.
// Ports: clk, rst (sync, active high); req0_*/req1_*
// valid/ready + a, b, oa; rsp_valid/rsp_ready + y, id.
module logical_seq_arb
  import logical_seq_arb_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_oa,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_oa,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_y,
  output logic                  rsp_id
);

  localparam int W  = 8 * NBYTES;
  localparam int IW =
    (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX =
    IW'(NBYTES - 1);

  // Tie goes to the requester that did not win last.
  function automatic logic [1:0] rr_pick(
    input logic v0,
    input logic v1,
    input logic last
  );
    if (v0 && v1) begin
      return last ? 2'b01 : 2'b10;
    end
    return {v1, v0};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  y_q, y_d;
  logic          oa_q, oa_d;
  logic          id_q, id_d;
  logic          last_q, last_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [1:0]    gnt;
  logic [7:0]    unit_a;
  logic [7:0]    unit_b;
  logic [7:0]    unit_y;

  logical u_logical (
    .A  (unit_a),
    .B  (unit_b),
    .OA (oa_q),
    .Y  (unit_y)
  );

  always_comb begin
    unit_a = 8'h00;
    unit_b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        unit_a = a_q[8*i +: 8];
        unit_b = b_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    y_d        = y_q;
    oa_d       = oa_q;
    id_d       = id_q;
    last_d     = last_q;
    idx_d      = idx_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gnt = rr_pick(req0_valid, req1_valid, last_q);

    unique case (state_q)
      ST_IDLE: begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        if (|gnt) begin
          a_d     = gnt[1] ? req1_a  : req0_a;
          b_d     = gnt[1] ? req1_b  : req0_b;
          oa_d    = gnt[1] ? req1_oa : req0_oa;
          id_d    = gnt[1];
          idx_d   = '0;
          y_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) begin
            y_d[8*i +: 8] = unit_y;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_RESP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      oa_q    <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      oa_q    <= oa_d;
      id_q    <= id_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_y     = y_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_logical_seq_arb.sv
// Scoreboard bench for logical_seq_arb (NBYTES=4)
// plus a directed check of an NBYTES=1 instance.
module tb_logical_seq_arb;

  localparam int NB = 4;

  typedef struct {
    bit          id;
    logic [31:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0;
  logic [31:0] req1_a = 0, req1_b = 0;
  logic        req0_oa = 0, req1_oa = 0;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_y;

  logic        d1_v0 = 0, d1_r0, d1_r1;
  logic [7:0]  d1_a0 = 0, d1_b0 = 0;
  logic        d1_oa0 = 0;
  logic        d1_v1 = 0, d1_oa1 = 0;
  logic [7:0]  d1_a1 = 0, d1_b1 = 0;
  logic        d1_rv, d1_id;
  logic [7:0]  d1_y;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t q[$];
  bit   grants[$];
  bit   busy = 0;
  bit   last = 1;
  bit   seen_v = 0;
  bit   hs0_seen = 0, hs1_seen = 0;
  int   hs_cyc = 0;
  int   cons_cyc = 0;
  logic [31:0] last_rsp_y = 0;
  bit   last_rsp_id = 0;

  logical_seq_arb #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_oa(req0_oa),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_oa(req1_oa),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id)
  );

  logical_seq_arb #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(d1_v0), .req0_ready(d1_r0),
    .req0_a(d1_a0), .req0_b(d1_b0), .req0_oa(d1_oa0),
    .req1_valid(d1_v1), .req1_ready(d1_r1),
    .req1_a(d1_a1), .req1_b(d1_b1), .req1_oa(d1_oa1),
    .rsp_valid(d1_rv), .rsp_ready(1'b1),
    .rsp_y(d1_y), .rsp_id(d1_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Monitor / scoreboard, sampled mid-cycle.
  initial forever begin
    bit   e0, e1;
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
      busy = 0; last = 1; seen_v = 0;
      hs0_seen = 0; hs1_seen = 0;
    end else begin
      e0 = !busy && req0_valid && (!req1_valid || last);
      e1 = !busy && req1_valid && (!req0_valid || !last);
      chk(req0_ready == e0, "req0_ready",
          64'(req0_ready), 64'(e0));
      chk(req1_ready == e1, "req1_ready",
          64'(req1_ready), 64'(e1));
      hs0_seen = req0_valid && req0_ready;
      hs1_seen = req1_valid && req1_ready;
      if (hs0_seen || hs1_seen) begin
        e.id = hs1_seen;
        if (hs1_seen)
          e.y = req1_oa ? (req1_a & req1_b)
                        : (req1_a | req1_b);
        else
          e.y = req0_oa ? (req0_a & req0_b)
                        : (req0_a | req0_b);
        q.push_back(e);
        grants.push_back(e.id);
        hs_cyc = cyc;
        busy = 1;
        seen_v = 0;
      end else if (rsp_valid) begin
        if (q.size() == 0) begin
          chk(0, "spurious_rsp", 64'(rsp_y), 0);
        end else begin
          if (!seen_v)
            chk(cyc == hs_cyc + NB + 1, "latency",
                64'(cyc - hs_cyc), 64'(NB + 1));
          seen_v = 1;
          chk(rsp_y == q[0].y, "rsp_y",
              64'(rsp_y), 64'(q[0].y));
          chk(rsp_id == q[0].id, "rsp_id",
              64'(rsp_id), 64'(q[0].id));
          if (rsp_ready) begin
            last_rsp_y  = q[0].y;
            last_rsp_id = q[0].id;
            last = q[0].id;
            void'(q.pop_front());
            busy = 0;
            cons_cyc = cyc;
          end
        end
      end else if (busy && cyc >= hs_cyc + NB + 1) begin
        chk(0, "missing_rsp", 64'(rsp_valid), 1);
        busy = 0;
        q.delete();
      end
    end
  end

  task automatic wait_hs(input bit any, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (hs0_seen || (any && hs1_seen)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(0, "hs_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(0, "idle_timeout", 0, 1);
    #1;
  endtask

  initial begin
    bit ok;
    int hc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(rsp_valid == 0, "rst_valid", 64'(rsp_valid), 0);
    chk(rsp_y == 0, "rst_y", 64'(rsp_y), 0);
    chk(rsp_id == 0, "rst_id", 64'(rsp_id), 0);
    @(posedge clk); #1;
    rst = 0;

    // 1: requester 0 alone
    req0_a = 32'hF0F01234; req0_b = 32'h0FF0FF00;
    req0_oa = 1; req0_valid = 1;
    wait_hs(0, ok); #1;
    req0_valid = 0;
    wait_idle();
    chk(last_rsp_y == 32'h00F01200, "t1_y",
        64'(last_rsp_y), 64'h00F01200);
    chk(last_rsp_id == 0, "t1_id", 64'(last_rsp_id), 0);

    // 2: requester 1 alone
    req1_a = 32'h80000001; req1_b = 32'h00000100;
    req1_oa = 0; req1_valid = 1;
    wait_hs(1, ok); #1;
    req1_valid = 0;
    wait_idle();
    chk(last_rsp_y == 32'h80000101, "t2_y",
        64'(last_rsp_y), 64'h80000101);
    chk(last_rsp_id == 1, "t2_id", 64'(last_rsp_id), 1);

    // 3: both valid from reset
    rst = 1; req0_valid = 1; req1_valid = 1;
    @(posedge clk); #1;
    rst = 0;
    grants.delete();
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (hs0_seen) begin
        req0_a = $urandom; req0_b = $urandom;
        req0_oa = 1'($urandom);
      end
      if (hs1_seen) begin
        req1_a = $urandom; req1_b = $urandom;
        req1_oa = 1'($urandom);
      end
      if (grants.size() >= 4) break;
    end
    req0_valid = 0; req1_valid = 0;
    chk(grants.size() >= 4, "t3_count",
        64'(grants.size()), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk(grants[i] == 1'(i), "t3_order",
          64'(grants[i]), 64'(i % 2));
    wait_idle();

    // 4: response back-pressure with req0 pending
    rsp_ready = 0;
    req0_a = 32'h12345678; req0_b = 32'hFF00FF00;
    req0_oa = 1; req0_valid = 1;
    wait_hs(0, ok); #1;
    req0_a = 32'hA5A5A5A5; req0_b = 32'h0000FFFF;
    req0_oa = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1;
    wait_hs(0, ok); #1;
    req0_valid = 0;
    chk(hs_cyc == cons_cyc + 1, "t4_accept",
        64'(hs_cyc - cons_cyc), 1);
    wait_idle();

    // 5: reset during byte 2 of RUN
    req0_a = 32'hDEADBEEF; req0_b = 32'h0F0F0F0F;
    req0_oa = 1; req0_valid = 1;
    wait_hs(0, ok); #1;
    req0_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk(rsp_valid == 0, "t5_valid", 64'(rsp_valid), 0);
    chk(rsp_y == 0, "t5_y", 64'(rsp_y), 0);
    repeat (8) @(posedge clk);
    #1 req0_valid = 1; req1_valid = 1;
    grants.delete();
    wait_hs(1, ok); #1;
    req0_valid = 0; req1_valid = 0;
    chk(grants.size() == 1 && grants[0] == 0, "t5_tie",
        64'(grants.size() > 0 ? grants[0] : 1), 0);
    wait_idle();

    // 6: single-byte instance
    d1_a0 = 8'h3C; d1_b0 = 8'h0F; d1_oa0 = 0;
    d1_v0 = 1;
    @(negedge clk);
    chk(d1_r0 == 1, "t6_ready", 64'(d1_r0), 1);
    hc = cyc;
    @(posedge clk); #1;
    d1_v0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d1_rv) break;
    end
    chk(d1_rv == 1 && cyc - hc == 2, "t6_lat",
        64'(cyc - hc), 2);
    chk(d1_y == 8'h3F, "t6_y", 64'(d1_y), 64'h3F);

    // random traffic
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!req0_valid || hs0_seen) begin
        req0_valid = 1'($urandom);
        req0_a = $urandom; req0_b = $urandom;
        req0_oa = 1'($urandom);
      end
      if (!req1_valid || hs1_seen) begin
        req1_valid = 1'($urandom);
        req1_a = $urandom; req1_b = $urandom;
        req1_oa = 1'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
    end
    rst = 0; req0_valid = 0; req1_valid = 0;
    rsp_ready = 1;
    wait_idle();
    chk(q.size() == 0, "drain", 64'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
